// File: rtl/sd_sector_reader_pkg.sv
// Shared constants and types for the SD sector reader and its SPI byte engine.
// Register map and control values match the SPI/SD register block at $0-$3.
package sd_sector_reader_pkg;

    localparam logic [2:0] AD_DATA_HI = 3'd0;
    localparam logic [2:0] AD_DATA_LO = 3'd1;
    localparam logic [2:0] AD_CTRL    = 3'd2;
    localparam logic [2:0] AD_PRESC   = 3'd3;

    localparam int         RDY_BIT    = 7;

    localparam logic [7:0] CTRL_SEL   = 8'h20;
    localparam logic [7:0] CTRL_DESEL = 8'h21;
    localparam logic [7:0] CMD17      = 8'h51;
    localparam logic [7:0] TOKEN_DATA = 8'hFE;
    localparam logic [7:0] FILL       = 8'hFF;

    typedef enum logic [2:0] {
        ERR_OK            = 3'd0,
        ERR_R1_TIMEOUT    = 3'd1,
        ERR_R1_BAD        = 3'd2,
        ERR_TOKEN_TIMEOUT = 3'd3,
        ERR_TOKEN_ERR     = 3'd4
    } err_code_e;

    typedef enum logic [3:0] {
        S_IDLE, S_SEL, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_DESEL, S_TAIL, S_DONE
    } rd_state_e;

    // CMD17 frame: opcode, big-endian LBA, dummy CRC byte
    function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [31:0] lba);
        case (idx)
            3'd0:    return CMD17;
            3'd1:    return lba[31:24];
            3'd2:    return lba[23:16];
            3'd3:    return lba[15:8];
            3'd4:    return lba[7:0];
            default: return FILL;
        endcase
    endfunction

endpackage

// File: rtl/sd_sector_reader_spi_byte_xfer.sv
// One SPI access sequence: data byte exchange via $1 (write, settle, poll RDY, read back)
// or a single control register write to $2. Owns the SPI block bus.
module sd_sector_reader_spi_byte_xfer
    import sd_sector_reader_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_go,
    input  logic       i_reg_wr,
    input  logic [7:0] i_tx,
    output logic [7:0] o_rx,
    output logic       o_done,
    output logic [2:0] o_spi_ad,
    output logic [7:0] o_spi_wdata,
    input  logic [7:0] i_spi_rdata,
    output logic       o_spi_rw,
    output logic       o_spi_cs
);

    typedef enum logic [2:0] {
        X_IDLE, X_WR, X_SETTLE, X_POLL, X_SAMPLE, X_RD, X_DONE
    } xfer_state_e;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    xfer_state_e r_state, w_next;
    logic [7:0]  r_tx;
    logic        r_reg_wr;
    logic [7:0]  r_settle;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= X_IDLE;
            r_tx     <= '0;
            r_reg_wr <= 1'b0;
            r_settle <= '0;
        end else begin
            r_state  <= w_next;
            if (r_state == X_IDLE && i_go) begin
                r_tx     <= i_tx;
                r_reg_wr <= i_reg_wr;
            end
            r_settle <= (r_state == X_SETTLE) ? r_settle + 8'd1 : 8'd0;
        end
    end

    // Every cs-high state is followed by a cs-low state so SPI start flags can clear
    always_comb begin
        w_next      = r_state;
        o_spi_ad    = AD_DATA_LO;
        o_spi_wdata = r_tx;
        o_spi_rw    = 1'b1;
        o_spi_cs    = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            X_IDLE:   if (i_go) w_next = X_WR;
            X_WR: begin
                o_spi_cs = 1'b1;
                o_spi_rw = 1'b0;
                o_spi_ad = r_reg_wr ? AD_CTRL : AD_DATA_LO;
                w_next   = r_reg_wr ? X_DONE : X_SETTLE;
            end
            X_SETTLE: if (r_settle == SETTLE_LAST) w_next = X_POLL;
            X_POLL: begin
                o_spi_cs = 1'b1;
                o_spi_ad = AD_CTRL;
                w_next   = X_SAMPLE;
            end
            X_SAMPLE: w_next = i_spi_rdata[RDY_BIT] ? X_RD : X_POLL;
            X_RD: begin
                o_spi_cs = 1'b1;
                w_next   = X_DONE;
            end
            X_DONE: begin
                o_done = 1'b1;
                w_next = X_IDLE;
            end
            default:  w_next = X_IDLE;
        endcase
    end

    assign o_rx = i_spi_rdata;

endmodule

// File: rtl/sd_sector_reader.sv
// CMD17 single-sector read sequencer: select card, send command, wait for R1 and the
// data token, stream 512 bytes into the buffer, drop CRC, deselect, report status.
module sd_sector_reader
    import sd_sector_reader_pkg::*;
#(
    parameter int SETTLE      = 2,
    parameter int R1_TRIES    = 8,
    parameter int TOKEN_TRIES = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_lba,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [2:0]  o_err_code,
    output logic [2:0]  o_spi_ad,
    output logic [7:0]  o_spi_wdata,
    input  logic [7:0]  i_spi_rdata,
    output logic        o_spi_rw,
    output logic        o_spi_cs,
    output logic        o_buf_we,
    output logic [8:0]  o_buf_addr,
    output logic [7:0]  o_buf_data
);

    localparam logic [12:0] R1_LAST  = 13'(R1_TRIES - 1);
    localparam logic [12:0] TOK_LAST = 13'(TOKEN_TRIES - 1);

    rd_state_e   r_state, w_next;
    logic [31:0] r_lba;
    logic [12:0] r_cnt;
    logic        r_wait;
    err_code_e   r_ecode, r_err_code, w_new_code;
    logic        r_err;
    logic [8:0]  r_addr;

    logic        w_go, w_reg_wr, w_xd, w_cnt_inc, w_set_err;
    logic [7:0]  w_tx, w_rx;

    sd_sector_reader_spi_byte_xfer #(.SETTLE(SETTLE)) u_xfer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_go        (w_go),
        .i_reg_wr    (w_reg_wr),
        .i_tx        (w_tx),
        .o_rx        (w_rx),
        .o_done      (w_xd),
        .o_spi_ad    (o_spi_ad),
        .o_spi_wdata (o_spi_wdata),
        .i_spi_rdata (i_spi_rdata),
        .o_spi_rw    (o_spi_rw),
        .o_spi_cs    (o_spi_cs)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_lba      <= '0;
            r_cnt      <= '0;
            r_wait     <= 1'b0;
            r_ecode    <= ERR_OK;
            r_err      <= 1'b0;
            r_err_code <= ERR_OK;
            r_addr     <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_cnt_inc)
                r_cnt <= r_cnt + 13'd1;
            if (w_go)
                r_wait <= 1'b1;
            else if (w_xd)
                r_wait <= 1'b0;
            if (w_set_err)
                r_ecode <= w_new_code;
            if (o_buf_we)
                r_addr <= r_addr + 9'd1;
            // Status becomes visible together with the done pulse
            if (r_state == S_TAIL && w_xd) begin
                r_err      <= (r_ecode != ERR_OK);
                r_err_code <= r_ecode;
            end
            if (r_state == S_IDLE && i_start) begin
                r_lba      <= i_lba;
                r_addr     <= '0;
                r_ecode    <= ERR_OK;
                r_err      <= 1'b0;
                r_err_code <= ERR_OK;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_tx       = FILL;
        w_reg_wr   = 1'b0;
        w_cnt_inc  = 1'b0;
        w_set_err  = 1'b0;
        w_new_code = ERR_OK;
        o_buf_we   = 1'b0;
        w_go       = !r_wait && (r_state != S_IDLE) && (r_state != S_DONE);
        case (r_state)
            S_IDLE: if (i_start) w_next = S_SEL;
            S_SEL: begin
                w_tx     = CTRL_SEL;
                w_reg_wr = 1'b1;
                if (w_xd) w_next = S_CMD;
            end
            S_CMD: begin
                w_tx = cmd_byte(r_cnt[2:0], r_lba);
                if (w_xd) begin
                    if (r_cnt == 13'd5) w_next = S_R1;
                    else                w_cnt_inc = 1'b1;
                end
            end
            S_R1: if (w_xd) begin
                if (w_rx == 8'h00) begin
                    w_next = S_TOKEN;
                end else if (w_rx == FILL) begin
                    if (r_cnt == R1_LAST) begin
                        w_set_err  = 1'b1;
                        w_new_code = ERR_R1_TIMEOUT;
                        w_next     = S_DESEL;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end else begin
                    w_set_err  = 1'b1;
                    w_new_code = ERR_R1_BAD;
                    w_next     = S_DESEL;
                end
            end
            // Anything that is neither the token nor an error token counts as a fill
            S_TOKEN: if (w_xd) begin
                if (w_rx == TOKEN_DATA) begin
                    w_next = S_DATA;
                end else if (w_rx[7:4] == 4'h0) begin
                    w_set_err  = 1'b1;
                    w_new_code = ERR_TOKEN_ERR;
                    w_next     = S_DESEL;
                end else if (r_cnt == TOK_LAST) begin
                    w_set_err  = 1'b1;
                    w_new_code = ERR_TOKEN_TIMEOUT;
                    w_next     = S_DESEL;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_DATA: if (w_xd) begin
                o_buf_we = 1'b1;
                if (r_cnt == 13'd511) w_next = S_CRC;
                else                  w_cnt_inc = 1'b1;
            end
            S_CRC: if (w_xd) begin
                if (r_cnt == 13'd1) w_next = S_DESEL;
                else                w_cnt_inc = 1'b1;
            end
            S_DESEL: begin
                w_tx     = CTRL_DESEL;
                w_reg_wr = 1'b1;
                if (w_xd) w_next = S_TAIL;
            end
            S_TAIL:  if (w_xd) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign o_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done     = (r_state == S_DONE);
    assign o_err      = r_err;
    assign o_err_code = r_err_code;
    assign o_buf_addr = r_addr;
    assign o_buf_data = w_rx;

endmodule

// File: tb/tb_sd_sector_reader.sv
// Directed bench for sd_sector_reader against a registered SPI/SD slave model
// with scripted MISO bytes and configurable RDY delay.
module tb_sd_sector_reader;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] lba;
    logic        busy, done, err;
    logic [2:0]  err_code;
    logic [2:0]  spi_ad;
    logic [7:0]  spi_wdata, spi_rdata;
    logic        spi_rw, spi_cs;
    logic        buf_we;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_data;

    always #5 clk = ~clk;

    sd_sector_reader dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_lba(lba),
        .o_busy(busy), .o_done(done), .o_err(err), .o_err_code(err_code),
        .o_spi_ad(spi_ad), .o_spi_wdata(spi_wdata), .i_spi_rdata(spi_rdata),
        .o_spi_rw(spi_rw), .o_spi_cs(spi_cs),
        .o_buf_we(buf_we), .o_buf_addr(buf_addr), .o_buf_data(buf_data)
    );

    // Card script configuration
    int         cfg_r1_after, cfg_tok_after, cfg_dly;
    logic [7:0] cfg_r1_val, cfg_tok_val, cfg_tok_fill;

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    function automatic logic [7:0] resp(input int k);
        int t0;
        if (k < 6 + cfg_r1_after)  return 8'hFF;
        if (k == 6 + cfg_r1_after) return cfg_r1_val;
        t0 = 7 + cfg_r1_after;
        if (k < t0 + cfg_tok_after)  return cfg_tok_fill;
        if (k == t0 + cfg_tok_after) return cfg_tok_val;
        if (k - t0 - cfg_tok_after - 1 < 512) return pat(k - t0 - cfg_tok_after - 1);
        return 8'hFF;
    endfunction

    // Slave model and monitor state
    logic [7:0] wr_log [0:4199];
    logic [7:0] ctrl_log [0:3];
    int         ctrl_pos [0:3];
    int         nwr, nctrl, nbuf, bbad, pbad, ndone, sc, dly;
    logic       rdy, prev_cs;
    logic [7:0] miso;

    always @(posedge clk) begin
        if (rst || (start && !busy && !done)) begin
            nwr <= 0; nctrl <= 0; nbuf <= 0; bbad <= 0; pbad <= 0; ndone <= 0;
            sc <= 0; dly <= 0; rdy <= 1'b0; miso <= 8'hFF; spi_rdata <= 8'h00;
        end else begin
            if (sc != 0) sc <= sc - 1;
            if (dly != 0) begin
                dly <= dly - 1;
                if (dly == 1) rdy <= 1'b1;
            end
            if (spi_cs) begin
                if (prev_cs || sc != 0) pbad <= pbad + 1;
                if (!spi_rw) begin
                    if (spi_ad == 3'd1) begin
                        if (nwr < 4200) wr_log[nwr] <= spi_wdata;
                        nwr  <= nwr + 1;
                        miso <= resp(nwr);
                        sc   <= SETTLE;
                        rdy  <= (cfg_dly == 0);
                        dly  <= cfg_dly;
                    end else if (spi_ad == 3'd2) begin
                        if (nctrl < 4) begin
                            ctrl_log[nctrl] <= spi_wdata;
                            ctrl_pos[nctrl] <= nwr;
                        end
                        nctrl <= nctrl + 1;
                    end else pbad <= pbad + 1;
                end else begin
                    if (spi_ad == 3'd2) spi_rdata <= {rdy, 7'h00};
                    else if (spi_ad == 3'd1) begin
                        if (!rdy) pbad <= pbad + 1;
                        spi_rdata <= miso;
                    end else pbad <= pbad + 1;
                end
            end
            if (buf_we) begin
                if (buf_addr != 9'(nbuf) || buf_data != pat(nbuf)) bbad <= bbad + 1;
                nbuf <= nbuf + 1;
            end
            if (done) begin
                ndone <= ndone + 1;
                if (busy) pbad <= pbad + 1;
            end
        end
        prev_cs <= spi_cs;
    end

    typedef struct {
        int         r1_after;
        logic [7:0] r1_val;
        int         tok_after;
        logic [7:0] tok_val;
        logic [7:0] tok_fill;
        int         dly;
        logic [31:0] lba;
        logic [2:0] code;
        int         nwr;
        int         nbuf;
    } vec_t;

    vec_t vecs [0:6];
    int   checks, errors;
    logic got_err;
    logic [2:0] got_code;
    logic seen;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic set_cfg(input vec_t v);
        cfg_r1_after = v.r1_after; cfg_r1_val = v.r1_val;
        cfg_tok_after = v.tok_after; cfg_tok_val = v.tok_val;
        cfg_tok_fill = v.tok_fill; cfg_dly = v.dly;
    endtask

    task automatic start_run(input logic [31:0] a, input string tag);
        @(negedge clk);
        start = 1'b1; lba = a;
        @(negedge clk);
        start = 1'b0; lba = 32'h0;
        check({tag, "_busy_after_start"}, busy, 1);
    endtask

    task automatic wait_done(input int max_cyc);
        seen = 1'b0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1; got_err = err; got_code = err_code;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [7:0] exp_tx(input int k, input logic [31:0] a);
        case (k)
            0: return 8'h51;
            1: return a[31:24];
            2: return a[23:16];
            3: return a[15:8];
            4: return a[7:0];
            default: return 8'hFF;
        endcase
    endfunction

    task automatic check_row(input vec_t v, input string tag);
        int seqbad;
        seqbad = 0;
        for (int k = 0; k < nwr && k < 4200; k++)
            if (wr_log[k] !== exp_tx(k, v.lba)) seqbad++;
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_err"}, got_err, (v.code != 3'd0));
        check({tag, "_err_code"}, got_code, v.code);
        check({tag, "_err_held"}, err, (v.code != 3'd0));
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_fill_writes"}, nwr, v.nwr);
        check({tag, "_tx_sequence_bad"}, seqbad, 0);
        check({tag, "_buf_writes"}, nbuf, v.nbuf);
        check({tag, "_buf_content_bad"}, bbad, 0);
        check({tag, "_done_pulses"}, ndone, 1);
        check({tag, "_ctrl_writes"}, nctrl, 2);
        check({tag, "_ctrl_sel"}, {ctrl_log[0], 24'(ctrl_pos[0])}, {8'h20, 24'd0});
        check({tag, "_ctrl_desel"}, {ctrl_log[1], 24'(ctrl_pos[1])}, {8'h21, 24'(v.nwr - 1)});
        check({tag, "_protocol_bad"}, pbad, 0);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; lba = 32'h0;
        cfg_r1_after = 0; cfg_r1_val = 8'h00; cfg_tok_after = 0;
        cfg_tok_val = 8'hFE; cfg_tok_fill = 8'hFF; cfg_dly = 0;

        //          r1_af   r1   tok_af  tok    fill   dly  lba           code nwr   nbuf
        vecs[0] = '{2,      8'h00, 10,     8'hFE, 8'hFF, 0,  32'h00012345, 3'd0, 535,  512};
        vecs[1] = '{100000, 8'h00, 0,      8'hFE, 8'hFF, 0,  32'h00000007, 3'd1, 15,   0};
        vecs[2] = '{0,      8'h05, 0,      8'hFE, 8'hFF, 0,  32'h11223344, 3'd2, 8,    0};
        vecs[3] = '{1,      8'h00, 3,      8'h08, 8'hFF, 0,  32'hCAFE0001, 3'd4, 13,   0};
        vecs[4] = '{1,      8'h00, 3,      8'h08, 8'hFF, 50, 32'hCAFE0001, 3'd4, 13,   0};
        vecs[5] = '{0,      8'h00, 100000, 8'hFE, 8'hFF, 0,  32'h00000100, 3'd3, 4104, 0};
        vecs[6] = '{0,      8'h00, 5,      8'hFE, 8'hF0, 3,  32'hA5A55A5A, 3'd0, 528,  512};

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_spi_cs", spi_cs, 0);
        check("rst_buf_we", buf_we, 0);
        check("rst_buf_addr", buf_addr, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            set_cfg(vecs[i]);
            start_run(vecs[i].lba, $sformatf("v%0d", i));
            wait_done(50000);
            check_row(vecs[i], $sformatf("v%0d", i));
        end

        // Reset in the middle of the data phase, then a clean full read
        set_cfg(vecs[0]);
        start_run(vecs[0].lba, "rstmid");
        seen = 1'b0;
        for (int c = 0; c < 20000 && !seen; c++) begin
            @(negedge clk);
            if (buf_we && buf_addr == 9'd200) seen = 1'b1;
        end
        check("rstmid_reach_addr200", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        check("rstmid_err", err, 0);
        check("rstmid_spi_cs", spi_cs, 0);
        check("rstmid_buf_we", buf_we, 0);
        check("rstmid_buf_addr", buf_addr, 0);
        rst = 1'b0;
        start_run(vecs[0].lba, "rstnew");
        wait_done(50000);
        check_row(vecs[0], "rstnew");

        // start while busy must be ignored, original LBA kept
        start_run(vecs[0].lba, "busystart");
        repeat (20) @(negedge clk);
        start = 1'b1; lba = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; lba = 32'h0;
        wait_done(50000);
        check_row(vecs[0], "busystart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
